// File: rtl/debug_unit.sv
// UART-side debug controller: decodes single-byte commands, loads instruction memory,
// runs or steps the pipeline and streams PC, registers and data memory back out.
module debug_unit #(
    parameter int NB_REG     = 32,
    parameter int NB_BYTE    = 8,
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_WORDS = 32
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_BYTE-1:0] i_rx_data,
    input  logic               i_rx_valid,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_start,
    input  logic               i_tx_busy,
    input  logic               i_halt,
    input  logic [NB_REG-1:0]  i_pc,
    input  logic [NB_REG-1:0]  i_dunit_reg,
    input  logic [NB_REG-1:0]  i_dunit_mem_data,
    output logic               o_dunit_clk_en,
    output logic               o_dunit_reset_pc,
    output logic               o_dunit_w_mem,
    output logic [NB_REG-1:0]  o_dunit_addr,
    output logic [NB_REG-1:0]  o_dunit_data_if
);

    localparam int PTR_W      = $clog2(IMEM_WORDS);
    localparam int DUMP_WORDS = 33 + DMEM_WORDS;
    localparam int IDX_W      = $clog2(DUMP_WORDS);

    localparam logic [NB_BYTE-1:0] CMD_LOAD  = 8'h4C;
    localparam logic [NB_BYTE-1:0] CMD_RUN   = 8'h43;
    localparam logic [NB_BYTE-1:0] CMD_STEP  = 8'h53;
    localparam logic [NB_BYTE-1:0] CMD_RESET = 8'h52;
    localparam logic [NB_BYTE-1:0] ACK_BYTE  = 8'h4B;

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(IMEM_WORDS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DUMP_WORDS - 1);

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        LOAD_WR,
        ACK,
        RUN,
        STEP,
        DUMP_RD,
        DUMP_TX,
        DUMP_WAIT
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [1:0]         byte_cnt;
    logic [NB_REG-1:0]  load_word;
    logic [IDX_W-1:0]   idx;
    logic [NB_REG-1:0]  dump_word;
    logic               wait_skip;

    // Dump slot 0 is the PC, 1..32 the register file, then data memory by byte address.
    function automatic logic [NB_REG-1:0] dump_addr(input logic [IDX_W-1:0] slot);
        if (slot == '0)
            return '0;
        else if (slot <= IDX_W'(32))
            return NB_REG'(slot - IDX_W'(1));
        else
            return NB_REG'(slot - IDX_W'(33)) << 2;
    endfunction

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state            <= IDLE;
            ptr              <= '0;
            byte_cnt         <= '0;
            load_word        <= '0;
            idx              <= '0;
            dump_word        <= '0;
            wait_skip        <= 1'b0;
            o_tx_data        <= '0;
            o_tx_start       <= 1'b0;
            o_dunit_clk_en   <= 1'b0;
            o_dunit_reset_pc <= 1'b0;
            o_dunit_w_mem    <= 1'b0;
            o_dunit_addr     <= '0;
            o_dunit_data_if  <= '0;
        end else begin
            o_tx_start    <= 1'b0;
            o_dunit_w_mem <= 1'b0;

            case (state)
                IDLE: begin
                    if (i_rx_valid) begin
                        case (i_rx_data)
                            CMD_LOAD: begin
                                o_dunit_reset_pc <= 1'b1;
                                byte_cnt         <= '0;
                                ptr              <= '0;
                                state            <= LOAD;
                            end
                            CMD_RUN: begin
                                o_dunit_clk_en <= 1'b1;
                                state          <= RUN;
                            end
                            CMD_STEP: begin
                                o_dunit_clk_en <= 1'b1;
                                state          <= STEP;
                            end
                            CMD_RESET: begin
                                o_dunit_reset_pc <= 1'b1;
                                state            <= ACK;
                            end
                            default: ;
                        endcase
                    end
                end

                LOAD: begin
                    if (i_rx_valid) begin
                        load_word <= {load_word[NB_REG-NB_BYTE-1:0], i_rx_data};
                        byte_cnt  <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            o_dunit_w_mem   <= 1'b1;
                            o_dunit_addr    <= NB_REG'({ptr, 2'b00});
                            o_dunit_data_if <= {load_word[NB_REG-NB_BYTE-1:0], i_rx_data};
                            state           <= LOAD_WR;
                        end
                    end
                end

                // The load stops on a HALT word or when instruction memory is full.
                LOAD_WR: begin
                    ptr <= ptr + PTR_W'(1);
                    if (o_dunit_data_if == '1 || ptr == LAST_PTR) begin
                        o_dunit_reset_pc <= 1'b0;
                        state            <= ACK;
                    end else begin
                        state <= LOAD;
                    end
                end

                ACK: begin
                    o_dunit_reset_pc <= 1'b0;
                    if (!i_tx_busy) begin
                        o_tx_data  <= ACK_BYTE;
                        o_tx_start <= 1'b1;
                        ptr        <= '0;
                        state      <= IDLE;
                    end
                end

                RUN: begin
                    if (i_halt) begin
                        o_dunit_clk_en <= 1'b0;
                        idx            <= '0;
                        byte_cnt       <= '0;
                        o_dunit_addr   <= dump_addr('0);
                        state          <= DUMP_RD;
                    end
                end

                STEP: begin
                    o_dunit_clk_en <= 1'b0;
                    idx            <= '0;
                    byte_cnt       <= '0;
                    o_dunit_addr   <= dump_addr('0);
                    state          <= DUMP_RD;
                end

                DUMP_RD: begin
                    if (idx == '0)
                        dump_word <= i_pc;
                    else if (idx <= IDX_W'(32))
                        dump_word <= i_dunit_reg;
                    else
                        dump_word <= i_dunit_mem_data;
                    state <= DUMP_TX;
                end

                DUMP_TX: begin
                    if (!i_tx_busy) begin
                        o_tx_data  <= dump_word[NB_REG-1 -: NB_BYTE];
                        o_tx_start <= 1'b1;
                        dump_word  <= {dump_word[NB_REG-NB_BYTE-1:0], {NB_BYTE{1'b0}}};
                        wait_skip  <= 1'b0;
                        state      <= DUMP_WAIT;
                    end
                end

                // One idle cycle gives the transmitter time to raise busy.
                DUMP_WAIT: begin
                    if (!wait_skip) begin
                        wait_skip <= 1'b1;
                    end else if (!i_tx_busy) begin
                        wait_skip <= 1'b0;
                        if (byte_cnt == 2'd3) begin
                            byte_cnt <= '0;
                            if (idx == LAST_IDX) begin
                                idx   <= '0;
                                state <= IDLE;
                            end else begin
                                idx          <= idx + IDX_W'(1);
                                o_dunit_addr <= dump_addr(idx + IDX_W'(1));
                                state        <= DUMP_RD;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                            state    <= DUMP_TX;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/debug_unit.md
# debug_unit

UART-side debug controller that drives the pipeline's debug port. It decodes single-byte commands from the UART receiver and acts on them. It loads program words into instruction memory, runs the pipeline continuously or one cycle at a time, and serialises PC, register file and data memory back through the UART transmitter. It sits between the UART RX/TX blocks and the `pipeline` top (`i_dunit_*` / `o_dunit_*` signals).

## Interface
Parameters:
- NB_REG, 32, datapath / word width
- NB_BYTE, 8, UART byte width
- IMEM_WORDS, 256, maximum program words per load
- DMEM_WORDS, 32, data-memory words included in a dump

Ports:
- i_clk  in  1  system clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_rx_data  in  8  received byte
- i_rx_valid  in  1  one-cycle strobe, i_rx_data valid
- o_tx_data  out  8  byte to transmit
- o_tx_start  out  1  one-cycle strobe, start transmission
- i_tx_busy  in  1  transmitter busy
- i_halt  in  1  pipeline retired HALT (0xFFFFFFFF) in WB
- i_pc  in  32  current PC
- i_dunit_reg  in  32  register-file read data at o_dunit_addr[4:0]
- i_dunit_mem_data  in  32  data-memory read data at o_dunit_addr
- o_dunit_clk_en  out  1  pipeline advance enable
- o_dunit_reset_pc  out  1  hold PC at 0
- o_dunit_w_mem  out  1  instruction-memory write strobe
- o_dunit_addr  out  32  write byte address / dump read address
- o_dunit_data_if  out  32  instruction word to write

## Operation
- Commands are accepted only in IDLE. Bytes arriving in RUN, STEP or DUMP are discarded.
- Command bytes:
  - 'L' (0x4C): load program.
  - 'C' (0x43): continuous run.
  - 'S' (0x53): single step.
  - 'R' (0x52): reset PC.
  - Any other byte: ignored.
- States: IDLE, LOAD, LOAD_WR, ACK, RUN, STEP, DUMP_RD, DUMP_TX, DUMP_WAIT.
- LOAD:
  - o_dunit_reset_pc=1 for the whole state.
  - Bytes are assembled big-endian (first byte = bits 31:24).
  - On the 4th byte, go to LOAD_WR: o_dunit_w_mem=1 for exactly one cycle, o_dunit_addr=4*ptr, o_dunit_data_if=word, then ptr++.
  - The load ends after writing 0xFFFFFFFF, or after writing word IMEM_WORDS-1 (no wrap). It then goes to ACK.
- ACK: send 0x4B ('K') once, then return to IDLE with ptr=0.
- 'R': o_dunit_reset_pc=1 for one cycle, then ACK.
- RUN: o_dunit_clk_en=1 every cycle until i_halt is sampled high. Then clk_en=0 and go to DUMP.
- STEP: o_dunit_clk_en=1 for exactly one cycle, then DUMP.
- DUMP sends 1+32+DMEM_WORDS words, each as 4 bytes MSB first:
  - index 0: PC.
  - indices 1..32: registers 0..31 (o_dunit_addr=r).
  - remaining indices: data memory word k (o_dunit_addr=4*k).
  - DUMP_RD: drive the address, capture the word into a shift register on the next edge.
  - DUMP_TX: pulse o_tx_start with the current byte when i_tx_busy=0.
  - DUMP_WAIT: skip one cycle, then wait for i_tx_busy=0.
  - After the last byte, return to IDLE.
- o_tx_start is never asserted while i_tx_busy=1.

## Timing
- Reset (i_reset=0, any time, asynchronous):
  - State goes to IDLE; ptr, the byte counter and the partial word are cleared.
  - All outputs go to 0: clk_en, reset_pc, w_mem, addr, data_if, tx_data, tx_start.
- Outputs are registered; the response follows the triggering i_rx_valid edge by one cycle.
- Load write: o_dunit_w_mem rises the cycle after the 4th byte's strobe. Address and data are stable during that cycle.
- RUN: clk_en rises the cycle after the 'C' strobe and falls the cycle after i_halt is first sampled high. If i_halt is already high on entry, clk_en is high for one cycle.
- STEP: clk_en is high for exactly one cycle. The first o_tx_start follows no earlier than 2 cycles later.
- Dump length: 4*(33+DMEM_WORDS) bytes, 132+4*DMEM_WORDS (260 with defaults).
- Simultaneous i_rx_valid and a state exit: the byte is dropped.

## Test plan
- Reset in every state: pull i_reset low mid-LOAD after 2 bytes -> all outputs 0, state IDLE. A following 'L' + 00 00 00 00 writes address 0 (partial word discarded).
- Load: 'L', 0x08 0x00 0x00 0x10, then 0xFF x4 -> w_mem pulses writing addr 0x0 data 0x08000010, then addr 0x4 data 0xFFFFFFFF. TX sends 0x4B. reset_pc=1 throughout the load.
- Overflow: load IMEM_WORDS non-HALT words -> last write at 4*(IMEM_WORDS-1), ACK sent, extra bytes ignored in IDLE.
- Step: 'S' with i_pc=0x40 and model registers/memory -> one clk_en cycle. 260 bytes out, first four 00 00 00 40. Register r is read at addr r, memory word k at addr 4k.
- Run: 'C', raise i_halt 20 cycles later -> clk_en high exactly 20 cycles, then a full dump. Bytes received during RUN are ignored.
- TX handshake: hold i_tx_busy high for 50 cycles after each start -> no start while busy, byte order preserved, no byte lost.
